// File: rtl/ref_pulse_gen_mc.sv
// Multi-channel burst reference-pulse generator: a shared period counter runs for
// cnt_nums periods (or forever) and each channel emits one delayed, sized pulse per period.
module ref_pulse_gen_mc #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32,
    parameter int WID_W = 16,
    parameter int NUM_W = 8
) (
    input  logic                   ref_clk_500m,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cont_mode,
    input  logic [NUM_W-1:0]       cnt_nums,
    input  logic [CNT_W-1:0]       sig_period,
    input  logic [NCH*CNT_W-1:0]   sig_start,
    input  logic [NCH*WID_W-1:0]   duty_cycle,
    input  logic [NCH-1:0]         polarity,
    output logic [NCH-1:0]         ref_signal,
    output logic                   busy,
    output logic                   done,
    output logic                   period_tick,
    output logic [NUM_W-1:0]       burst_idx,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic                 r_start_d;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_W-1:0]     r_bidx;
    logic                 r_done;
    logic                 r_tick;
    logic [NCH-1:0]       r_ref;

    logic                 r_cont_l;
    logic [NUM_W-1:0]     r_nums_l;
    logic [CNT_W-1:0]     r_period_l;
    logic [NCH*CNT_W-1:0] r_start_l;
    logic [NCH*WID_W-1:0] r_width_l;
    logic [NCH-1:0]       r_pol_l;

    logic                 w_start_edge;
    logic                 w_cfg_ok;
    logic                 w_accept;
    logic                 w_wrap;
    logic                 w_last;
    logic [NCH-1:0]       w_act;

    assign w_start_edge = start & ~r_start_d;
    assign w_cfg_ok     = (sig_period != '0) && (cont_mode || (cnt_nums != '0));
    assign w_accept     = w_start_edge && w_cfg_ok && (r_state != S_RUN);
    assign w_wrap       = (r_cnt == r_period_l - CNT_W'(1));
    assign w_last       = w_wrap && !r_cont_l && (r_bidx == r_nums_l - NUM_W'(1));

    // Window compare at CNT_W+1 bits so start+width can never wrap around.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CNT_W:0] w_lo;
        logic [CNT_W:0] w_hi;
        assign w_lo     = {1'b0, r_start_l[c*CNT_W +: CNT_W]};
        assign w_hi     = w_lo + {{(CNT_W-WID_W+1){1'b0}}, r_width_l[c*WID_W +: WID_W]};
        assign w_act[c] = ({1'b0, r_cnt} >= w_lo) && ({1'b0, r_cnt} < w_hi);
    end

    always_ff @(posedge ref_clk_500m) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_accept) w_state_nx = S_RUN;
            S_RUN: begin
                if (stop)        w_state_nx = S_IDLE;
                else if (w_last) w_state_nx = S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_RUN);
        dbg_state = r_state;
    end

    always_ff @(posedge ref_clk_500m) begin
        if (reset) begin
            r_start_d  <= 1'b0;
            r_cnt      <= '0;
            r_bidx     <= '0;
            r_done     <= 1'b0;
            r_tick     <= 1'b0;
            r_ref      <= polarity;
            r_cont_l   <= 1'b0;
            r_nums_l   <= '0;
            r_period_l <= '0;
            r_start_l  <= '0;
            r_width_l  <= '0;
            r_pol_l    <= '0;
        end else begin
            r_start_d <= start;
            r_tick    <= 1'b0;
            if (w_accept) begin
                r_cont_l   <= cont_mode;
                r_nums_l   <= cnt_nums;
                r_period_l <= sig_period;
                r_start_l  <= sig_start;
                r_width_l  <= duty_cycle;
                r_pol_l    <= polarity;
                r_cnt      <= '0;
                r_bidx     <= '0;
                r_done     <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (stop) begin
                    r_cnt <= '0;
                end else if (w_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_bidx <= r_bidx + NUM_W'(1);
                    if (w_last) r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            // The cycle after the final cnt still shows that cnt's pulse; idle shows polarity.
            if ((r_state == S_RUN) && !stop) r_ref <= w_act ^ r_pol_l;
            else if (w_state_nx == S_DONE)   r_ref <= r_pol_l;
            else                             r_ref <= polarity;
        end
    end

    assign ref_signal  = r_ref;
    assign done        = r_done;
    assign period_tick = r_tick;
    assign burst_idx   = r_bidx;

endmodule

// File: tb/tb_ref_pulse_gen_mc.sv
// Bench for ref_pulse_gen_mc: per-cycle expected outputs come from a closed-form run model,
// are queued when a start is driven, and are popped and compared every cycle.
module tb_ref_pulse_gen_mc;
    localparam int NCH   = 4;
    localparam int CNT_W = 32;
    localparam int WID_W = 16;
    localparam int NUM_W = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 stop;
    logic                 cont_mode;
    logic [NUM_W-1:0]     cnt_nums;
    logic [CNT_W-1:0]     sig_period;
    logic [NCH*CNT_W-1:0] sig_start;
    logic [NCH*WID_W-1:0] duty_cycle;
    logic [NCH-1:0]       polarity;
    logic [NCH-1:0]       ref_signal;
    logic                 busy;
    logic                 done;
    logic                 period_tick;
    logic [NUM_W-1:0]     burst_idx;
    logic [1:0]           dbg_state;

    ref_pulse_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .WID_W(WID_W), .NUM_W(NUM_W)) dut (
        .ref_clk_500m(clk), .reset(reset), .start(start), .stop(stop),
        .cont_mode(cont_mode), .cnt_nums(cnt_nums), .sig_period(sig_period),
        .sig_start(sig_start), .duty_cycle(duty_cycle), .polarity(polarity),
        .ref_signal(ref_signal), .busy(busy), .done(done), .period_tick(period_tick),
        .burst_idx(burst_idx), .dbg_state(dbg_state)
    );

    always #1 clk = ~clk;

    // Observed vector: {busy, done, period_tick, ref_signal[3:0], burst_idx[7:0]}
    logic [14:0] obs;
    assign obs = {busy, done, period_tick, ref_signal, burst_idx};

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [14:0] exp_q[$];

    int          cfg_p;
    int          cfg_n;
    bit          cfg_cont;
    int          cfg_s[NCH];
    int          cfg_w[NCH];
    logic [3:0]  cfg_pol;

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s @%0t: got busy/done/tick/ref/idx=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     tag, $time, got[14], got[13], got[12], got[11:8], got[7:0],
                     want[14], want[13], want[12], want[11:8], want[7:0]);
        end
    endtask

    task automatic step_chk(input string tag);
        @(negedge clk);
        if (exp_q.size() == 0) chk({tag, "_underflow"}, obs, ~obs);
        else                   chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic apply_cfg();
        cont_mode  = cfg_cont;
        cnt_nums   = 8'(cfg_n);
        sig_period = 32'(cfg_p);
        for (int c = 0; c < NCH; c++) begin
            sig_start[c*CNT_W +: CNT_W]  = 32'(cfg_s[c]);
            duty_cycle[c*WID_W +: WID_W] = 16'(cfg_w[c]);
        end
        polarity = cfg_pol;
    endtask

    // Expected outputs in cycle k+j of a run whose start edge was sampled at edge k.
    function automatic logic [14:0] exp_run(input int j);
        int         total;
        int         cp;
        logic       e_busy;
        logic       e_tick;
        logic [3:0] e_ref;
        logic [7:0] e_idx;
        total = cfg_cont ? 32'h3fff_ffff : cfg_n * cfg_p;
        if (j > total + 1) return {1'b0, 1'b1, 1'b0, cfg_pol, 8'(cfg_n)};
        e_busy = (j <= total);
        e_tick = (j >= 2) && (((j - 1) % cfg_p) == 0);
        e_idx  = 8'((j - 1) / cfg_p);
        for (int c = 0; c < NCH; c++) begin
            if (j == 1) begin
                e_ref[c] = cfg_pol[c];
            end else begin
                cp = (j - 2) % cfg_p;
                e_ref[c] = ((cp >= cfg_s[c]) && (cp < cfg_s[c] + cfg_w[c])) ^ cfg_pol[c];
            end
        end
        return {e_busy, ~e_busy, e_tick, e_ref, e_idx};
    endfunction

    // kind: 0 plain, 1 stop at cycle 'at', 2 stop+start at 'at', 3 reset at 'at'
    task automatic run_burst(input string tag, input int len, input int at, input int kind);
        logic [14:0] abort_v;
        abort_v = {3'b000, cfg_pol, (kind == 3) ? 8'h00 : 8'((at - 1) / cfg_p)};
        apply_cfg();
        start = 1'b1;
        for (int j = 1; j <= len; j++) begin
            if (kind != 0 && j > at) exp_q.push_back(abort_v);
            else                     exp_q.push_back(exp_run(j));
        end
        for (int j = 1; j <= len; j++) begin
            step_chk(tag);
            if (j == 1) start = 1'b0;
            if (kind != 0 && j == at) begin
                if (kind == 1 || kind == 2) stop = 1'b1;
                if (kind == 2) start = 1'b1;
                if (kind == 3) reset = 1'b1;
            end
            if (kind != 0 && j == at + 1) begin
                stop  = 1'b0;
                start = 1'b0;
                reset = 1'b0;
            end
        end
    endtask

    task automatic try_reject(input string tag, input logic [14:0] hold, input int len);
        start = 1'b1;
        for (int j = 0; j < len; j++) exp_q.push_back(hold);
        for (int j = 0; j < len; j++) begin
            step_chk(tag);
            start = 1'b0;
        end
    endtask

    task automatic cfg_burst_a();
        cfg_p = 10; cfg_n = 3; cfg_cont = 1'b0; cfg_pol = 4'b1000;
        cfg_s[0] = 2; cfg_w[0] = 3;
        cfg_s[1] = 0; cfg_w[1] = 10;
        cfg_s[2] = 5; cfg_w[2] = 0;
        cfg_s[3] = 8; cfg_w[3] = 5;
    endtask

    initial begin
        logic [14:0] hold;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_burst_a();
        apply_cfg();
        repeat (3) @(posedge clk);
        exp_q.push_back({3'b000, cfg_pol, 8'h00});
        step_chk("reset");
        reset = 1'b0;
        repeat (2) exp_q.push_back({3'b000, cfg_pol, 8'h00});
        repeat (2) step_chk("idle");

        run_burst("burst_a", 34, 0, 0);

        // Config changes and a second start edge mid-run must not alter the run.
        apply_cfg();
        start = 1'b1;
        for (int j = 1; j <= 34; j++) exp_q.push_back(exp_run(j));
        for (int j = 1; j <= 34; j++) begin
            step_chk("shadow");
            if (j == 1) start = 1'b0;
            if (j == 12) begin
                sig_period = 32'd20; cnt_nums = 8'd7; polarity = ~cfg_pol;
                sig_start[31:0] = 32'd0; start = 1'b1;
            end
            if (j == 13) start = 1'b0;
        end

        hold = exp_run(cfg_n * cfg_p + 2);
        sig_period = 32'd0;
        try_reject("rej_done", hold, 4);

        cfg_p = 20; cfg_n = 2; cfg_pol = 4'b0101;
        cfg_s[0] = 19; cfg_w[0] = 1;
        cfg_s[2] = 20; cfg_w[2] = 3;
        run_burst("restart", 44, 0, 0);

        cfg_p = 1; cfg_n = 3; cfg_pol = 4'b1000;
        cfg_s[0] = 0; cfg_w[0] = 1;
        cfg_s[1] = 1; cfg_w[1] = 1;
        cfg_s[2] = 0; cfg_w[2] = 0;
        cfg_s[3] = 0; cfg_w[3] = 5;
        run_burst("period1", 6, 0, 0);

        cfg_p = 4; cfg_n = 0; cfg_cont = 1'b1; cfg_pol = 4'b0010;
        cfg_s[0] = 1; cfg_w[0] = 2;
        cfg_s[1] = 3; cfg_w[1] = 4;
        cfg_s[2] = 0; cfg_w[2] = 4;
        cfg_s[3] = 2; cfg_w[3] = 0;
        run_burst("cont", 1215, 1210, 1);

        hold = {3'b000, cfg_pol, 8'((1210 - 1) / 4)};
        cfg_cont = 1'b0; cfg_n = 0; cfg_p = 5;
        apply_cfg();
        try_reject("rej_nums0", hold, 4);
        cfg_cont = 1'b1; cfg_n = 3; cfg_p = 0;
        apply_cfg();
        try_reject("rej_per0", hold, 4);

        cfg_cont = 1'b0; cfg_p = 5; cfg_n = 2;
        run_burst("stop_start", 8, 3, 2);

        cfg_burst_a();
        run_burst("rst_mid", 20, 16, 3);
        run_burst("after_rst", 34, 0, 0);

        if (exp_q.size() != 0) chk("queue_drain", 15'(exp_q.size()), 15'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
